// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared types and constants for the multicycle controller
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - combinational aluop/funct to alucontrol mapping
module alu_decoder
  import mc_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUC_ADD;
          FUNCT_SUB: alucontrol = ALUC_SUB;
          FUNCT_AND: alucontrol = ALUC_AND;
          FUNCT_OR:  alucontrol = ALUC_OR;
          FUNCT_SLT: alucontrol = ALUC_SLT;
          default:   alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - Moore FSM controller for a multicycle MIPS-style datapath
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state, state_next;
  aluop_t aluop;
  logic   pcwrite, branch;
  logic   irwrite_raw, regwrite_raw, memwrite_raw, done_raw, illegal_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEXEC;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTE:  state_next = S_ALUWB;
      S_ADDIEXEC: state_next = S_ADDIWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    aluop        = ALUOP_ADD;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      S_DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = !op_known(op);
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        done_raw     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        done_raw     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        branch   = 1'b1;
        pcsrc    = 2'b01;
        done_raw = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign pcen       = rst_n & (pcwrite | (branch & zero));
  assign irwrite    = rst_n & irwrite_raw;
  assign regwrite   = rst_n & regwrite_raw;
  assign memwrite   = rst_n & memwrite_raw;
  assign instr_done = rst_n & done_raw;
  assign illegal_op = rst_n & illegal_raw;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       instr_done;
    logic       illegal_op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg;
  logic       instr_done, illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alucontrol (alucontrol),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = '{alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
          irwrite, regwrite, regdst, memtoreg, instr_done, illegal_op};
    return o;
  endfunction

  // Instruction latency in cycles, FETCH included.
  function automatic int model_len(input logic [5:0] o);
    case (o)
      6'b100011:                    return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:         return 3;
      default:                      return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_map(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic exp_t reset_vec();
    exp_t e;
    e = '0;
    e.alucontrol = 3'b010;
    e.alusrcb    = 2'b01;
    return e;
  endfunction

  // Expected outputs for cycle k of an instruction, derived from its class.
  function automatic exp_t model_out(input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input int k);
    exp_t e;
    int   len;
    len = model_len(o);
    e = '0;
    e.alucontrol = 3'b010;
    if (k == 0) begin
      e.irwrite = 1'b1;
      e.pcen    = 1'b1;
      e.alusrcb = 2'b01;
    end else if (k == 1) begin
      e.alusrcb    = 2'b11;
      e.illegal_op = (len == 2);
    end else begin
      e.instr_done = (k == len - 1);
      case (o)
        6'b100011, 6'b101011: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
          end else if (o == 6'b100011 && k == 3) begin
            e.iord = 1'b1;
          end else if (o == 6'b100011) begin
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
          end else begin
            e.iord     = 1'b1;
            e.memwrite = 1'b1;
          end
        end
        6'b000000: begin
          if (k == 2) begin
            e.alusrca    = 1'b1;
            e.alucontrol = funct_map(f);
          end else begin
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
          end
        end
        6'b001000: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
          end else begin
            e.regwrite = 1'b1;
          end
        end
        6'b000100: begin
          e.alusrca    = 1'b1;
          e.alucontrol = 3'b110;
          e.pcsrc      = 2'b01;
          e.pcen       = z;
        end
        6'b000010: begin
          e.pcen  = 1'b1;
          e.pcsrc = 2'b10;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH. zmode 0/1 forces zero, 2 randomizes.
  // abort_at >= 0 asserts reset in that cycle instead of completing the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int abort_at);
    int len;
    int done_cnt;
    len = model_len(o);
    done_cnt = 0;
    op = o;
    funct = f;
    for (int k = 0; k < len; k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(1, 0)) : 1'(zmode);
      @(negedge clk);
      check($sformatf("op%06b_f%06b_k%0d", o, f, k), 32'(observed()),
            32'(model_out(o, f, zero, k)));
      done_cnt += int'(instr_done);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_memwrite", 32'(memwrite), 32'd0);
        check("abort_vec", 32'(observed()), 32'(reset_vec()));
        @(posedge clk);
        #1;
        check("abort_hold_vec", 32'(observed()), 32'(reset_vec()));
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("done_cnt_op%06b", o), 32'(done_cnt), (len > 2) ? 32'd1 : 32'd0);
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] legal_functs [5];

  initial begin
    legal_ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    legal_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_vec", 32'(observed()), 32'(reset_vec()));
    @(posedge clk);
    #1;
    check("reset_hold_vec", 32'(observed()), 32'(reset_vec()));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(6'b100011, 6'b000000, 2, -1);
    run_instr(6'b000000, 6'b101010, 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(6'b000010, 6'b000000, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, 3);
    run_instr(6'b100011, 6'b100000, 2, -1);

    for (int i = 0; i < 80; i++) begin
      logic [5:0] o;
      logic [5:0] f;
      o = ($urandom_range(5, 0) == 0) ? 6'($urandom) : legal_ops[$urandom_range(5, 0)];
      f = ($urandom_range(3, 0) == 0) ? 6'($urandom) : legal_functs[$urandom_range(4, 0)];
      run_instr(o, f, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 Port list, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- alucontrol  out  3  ALU function select for the downstream ALU
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC load enable
- iord  out  1  0 = PC address, 1 = ALUOut address
- memwrite, irwrite, regwrite  out  1 each  write strobes
- regdst, memtoreg  out  1 each  write-back selects
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-004 State transitions SHALL be:
- FETCH -> DECODE.
- DECODE on op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; any other opcode -> FETCH.
- MEMADR -> MEMRD for lw, MEMWR for sw.
- MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
REQ-005 Outputs SHALL be decoded from the state. Every signal not listed for a state SHALL be 0.
- FETCH: irwrite = 1, pcwrite = 1, alusrcb = 01, aluop = 00.
- DECODE: alusrcb = 11, aluop = 00.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00.
- MEMRD: iord = 1.
- MEMWB: regwrite = 1, memtoreg = 1.
- MEMWR: iord = 1, memwrite = 1.
- EXECUTE: alusrca = 1, aluop = 10.
- ALUWB: regwrite = 1, regdst = 1.
- BRANCH: alusrca = 1, aluop = 01, branch = 1, pcsrc = 01.
- ADDIEXEC: alusrca = 1, alusrcb = 10, aluop = 00.
- ADDIWB: regwrite = 1.
- JUMP: pcwrite = 1, pcsrc = 10.
REQ-006 pcen SHALL equal pcwrite OR (branch AND zero), computed combinationally and with the same cycle as zero.
REQ-007 alucontrol SHALL be derived from aluop and funct:
- aluop 00 -> 010; aluop 01 -> 110.
- aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
- aluop 11 -> 010.
REQ-008 instr_done SHALL be 1 exactly in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
REQ-009 illegal_op SHALL be 1 only in DECODE with an unrecognised op.
REQ-010 Instruction latency SHALL be, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles.

Reset
REQ-011 rst_n low SHALL force the state to FETCH asynchronously.
REQ-012 While rst_n is low, pcen, irwrite, regwrite, memwrite, instr_done and illegal_op SHALL be 0, and the other outputs SHALL take their FETCH values.
REQ-013 The first FETCH with strobes active SHALL occur in the first clock cycle after rst_n deasserts.
REQ-014 Reset asserted in any state mid-instruction SHALL abandon that instruction with no further write strobes.

Structure
REQ-015 A shared package SHALL hold the state enumeration, the opcode and funct constants, the aluop codes, and the alucontrol codes (AND 000, OR 001, ADD 010, SUB 110, SLT 111).
REQ-016 The aluop/funct-to-alucontrol mapping SHALL be a combinational sub-module named alu_decoder. The FSM and the output decode SHALL remain in mc_controller.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then op = 100011: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite = memtoreg = 1 in cycle 5; instr_done pulses once.
- op = 000000, funct = 101010: alucontrol = 111 in EXECUTE; regdst = regwrite = 1 next cycle; 4 cycles total.
- op = 000100, zero = 1 in BRANCH: pcen = 1, pcsrc = 01, alucontrol = 110. Repeat with zero = 0: pcen = 0.
- op = 111111: illegal_op pulses in DECODE; returns to FETCH; no write strobes.
- op = 000010: pcen = 1, pcsrc = 10 in cycle 3; the next cycle is FETCH.
- rst_n pulsed low during MEMWR: memwrite drops immediately; FETCH strobes resume one cycle after release.
